// File: rtl/ncl_wavefront_driver.sv
// ncl_wavefront_driver
//
// Synchronous bridge around a four-input, one-output NULL-convention
// dual-rail combinational stage. Accepts a 4-bit single-rail operand, drives
// it as a DATA wavefront on A..D, waits for Q to complete, returns the rails
// to NULL, waits for Q to return to NULL, then offers the captured result
// and an error code.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid/in_ready     operand handshake; in_ready only in IDLE
//   in_data[3:0]          operand, bit3=A, bit2=B, bit1=C, bit0=D
//   A_t..D_f              registered dual-rail drive into the stage
//   Q_t, Q_f              dual-rail result from the stage (asynchronous)
//   out_valid/out_ready   result handshake; out_valid only in RESULT
//   out_q                 Q_t captured at DATA completion
//   out_err[1:0]          00 ok, 01 timeout, 10 illegal Q (both rails high)
//
// SETTLE_CYCLES (>=1): consecutive synchronized cycles Q must hold a phase's
// completion condition. TIMEOUT (>=SETTLE_CYCLES+2): max cycles per phase.
module ncl_wavefront_driver #(
  parameter int SETTLE_CYCLES = 2,
  parameter int TIMEOUT       = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_data,
  output logic       A_t,
  output logic       A_f,
  output logic       B_t,
  output logic       B_f,
  output logic       C_t,
  output logic       C_f,
  output logic       D_t,
  output logic       D_f,
  input  logic       Q_t,
  input  logic       Q_f,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_q,
  output logic [1:0] out_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] SETTLE_C  = CW'(SETTLE_CYCLES);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_NULL,
    S_RESULT
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    rails_q, rails_d;     // {A_t,A_f,B_t,B_f,C_t,C_f,D_t,D_f}
  logic [CW-1:0] ph_q, ph_d;           // cycles spent in the current phase
  logic [CW-1:0] st_q, st_d;           // consecutive cycles condition held
  logic          outq_q, outq_d;
  logic [1:0]    err_q, err_d;
  logic          qt_meta_q, qf_meta_q;
  logic          qt_s_q, qf_s_q;

  logic [CW-1:0] ph_inc, st_inc;
  logic          data_cond, null_cond, both_high;

  // Counters stick at TIMEOUT instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v >= TIMEOUT_C) ? v : v + CW'(1);
  endfunction

  // Single-rail to dual-rail: X_t = bit, X_f = ~bit, A in the top pair.
  function automatic logic [7:0] encode(input logic [3:0] d);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[2*i+1] = d[i];
      r[2*i]   = ~d[i];
    end
    return r;
  endfunction

  assign ph_inc    = sat_inc(ph_q);
  assign st_inc    = sat_inc(st_q);
  assign data_cond = qt_s_q ^ qf_s_q;
  assign null_cond = ~qt_s_q & ~qf_s_q;
  assign both_high = qt_s_q & qf_s_q;

  always_comb begin
    state_d = state_q;
    rails_d = rails_q;
    ph_d    = ph_inc;
    st_d    = '0;
    outq_d  = outq_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        ph_d = '0;
        if (in_valid) begin
          state_d = S_DATA;
          rails_d = encode(in_data);
          outq_d  = 1'b0;
          err_d   = ERR_OK;
        end
      end
      S_DATA: begin
        if (data_cond) st_d = st_inc;
        // Illegal Q outranks completion and timeout.
        if (both_high) begin
          state_d = S_NULL;
          rails_d = '0;
          outq_d  = 1'b0;
          err_d   = ERR_ILLEGAL;
        end else if (data_cond && (st_inc >= SETTLE_C)) begin
          state_d = S_NULL;
          rails_d = '0;
          outq_d  = qt_s_q;
          err_d   = ERR_OK;
        end else if (ph_inc >= TIMEOUT_C) begin
          state_d = S_NULL;
          rails_d = '0;
          outq_d  = 1'b0;
          err_d   = ERR_TIMEOUT;
        end
      end
      S_NULL: begin
        if (null_cond) st_d = st_inc;
        // Only the first error of an operand is reported.
        if (both_high && (err_q == ERR_OK)) err_d = ERR_ILLEGAL;
        if (null_cond && (st_inc >= SETTLE_C)) begin
          state_d = S_RESULT;
        end else if (ph_inc >= TIMEOUT_C) begin
          state_d = S_RESULT;
          if (err_d == ERR_OK) err_d = ERR_TIMEOUT;
        end
      end
      S_RESULT: begin
        ph_d = '0;
        if (out_ready) state_d = S_IDLE;
      end
    endcase
    if (state_d != state_q) begin
      ph_d = '0;
      st_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rails_q   <= '0;
      ph_q      <= '0;
      st_q      <= '0;
      outq_q    <= 1'b0;
      err_q     <= ERR_OK;
      qt_meta_q <= 1'b0;
      qf_meta_q <= 1'b0;
      qt_s_q    <= 1'b0;
      qf_s_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rails_q   <= rails_d;
      ph_q      <= ph_d;
      st_q      <= st_d;
      outq_q    <= outq_d;
      err_q     <= err_d;
      // Two-flop synchronizers; Q comes from an unclocked stage.
      qt_meta_q <= Q_t;
      qf_meta_q <= Q_f;
      qt_s_q    <= qt_meta_q;
      qf_s_q    <= qf_meta_q;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_RESULT);
  assign out_q     = outq_q;
  assign out_err   = err_q;
  assign {A_t, A_f, B_t, B_f, C_t, C_f, D_t, D_f} = rails_q;

endmodule

// File: tb/tb_ncl_wavefront_driver.sv
// Directed bench for ncl_wavefront_driver with a small dual-rail AND stage
// model (Q = A & B) and a manual Q override for glitch/stuck/illegal cases.
module tb_ncl_wavefront_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       A_t, A_f, B_t, B_f, C_t, C_f, D_t, D_f;
  logic       Q_t, Q_f;
  logic       out_valid;
  logic       out_ready;
  logic       out_q;
  logic [1:0] out_err;

  logic       man;
  logic       qt_m, qf_m;
  logic [7:0] rails;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  // Zero-delay dual-rail AND: true when both true, false when either false.
  assign Q_t   = man ? qt_m : (A_t & B_t);
  assign Q_f   = man ? qf_m : (A_f | B_f);
  assign rails = {A_t, A_f, B_t, B_f, C_t, C_f, D_t, D_f};

  ncl_wavefront_driver #(
    .SETTLE_CYCLES(2),
    .TIMEOUT      (20)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .A_t      (A_t),
    .A_f      (A_f),
    .B_t      (B_t),
    .B_f      (B_f),
    .C_t      (C_t),
    .C_f      (C_f),
    .D_t      (D_t),
    .D_f      (D_f),
    .Q_t      (Q_t),
    .Q_f      (Q_f),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_q    (out_q),
    .out_err  (out_err)
  );

  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Offer one operand in IDLE; returns just after the accept edge E0.
  task automatic accept(input logic [3:0] d);
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("consume_valid", 8'(out_valid), 8'h00);
    chk("consume_ready", 8'(in_ready), 8'h01);
  endtask

  task automatic run_nominal(input logic [3:0] d, input logic [7:0] exp_rails,
                             input logic exp_q);
    accept(d);
    chk("nom_rails_e0", rails, exp_rails);
    chk("nom_ready_e0", 8'(in_ready), 8'h00);
    ticks(3);
    chk("nom_rails_e3", rails, exp_rails);
    tick();
    chk("nom_null_e4", rails, 8'h00);
    ticks(3);
    chk("nom_valid_e7", 8'(out_valid), 8'h00);
    tick();
    chk("nom_valid_e8", 8'(out_valid), 8'h01);
    chk("nom_q", 8'(out_q), 8'(exp_q));
    chk("nom_err", 8'(out_err), 8'h00);
    consume();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 4'h0;
    out_ready = 1'b0;
    man       = 1'b0;
    qt_m      = 1'b0;
    qf_m      = 1'b0;

    // Reset and idle
    ticks(3);
    chk("rst_rails", rails, 8'h00);
    chk("rst_ready", 8'(in_ready), 8'h01);
    chk("rst_valid", 8'(out_valid), 8'h00);
    chk("rst_err", 8'(out_err), 8'h00);
    chk("rst_q", 8'(out_q), 8'h00);
    rst_n = 1'b1;
    ticks(2);
    chk("idle_rails", rails, 8'h00);
    chk("idle_ready", 8'(in_ready), 8'h01);
    chk("idle_valid", 8'(out_valid), 8'h00);

    // Nominal: A&B = 1, then A&B = 0
    run_nominal(4'b1100, 8'b1010_0101, 1'b1);
    run_nominal(4'b0111, 8'b0110_1010, 1'b0);

    // Glitch: Q true 1 cycle, NULL 1 cycle, then settles false
    man = 1'b1; qt_m = 1'b0; qf_m = 1'b0;
    accept(4'b0100);
    qt_m = 1'b1; qf_m = 1'b0;
    tick();
    qt_m = 1'b0; qf_m = 1'b0;
    tick();
    qt_m = 1'b0; qf_m = 1'b1;
    ticks(3);
    chk("glitch_rails_e5", rails, 8'b0110_0101);
    tick();
    chk("glitch_null_e6", rails, 8'h00);
    qt_m = 1'b0; qf_m = 1'b0;
    ticks(3);
    chk("glitch_valid_e9", 8'(out_valid), 8'h00);
    tick();
    chk("glitch_valid_e10", 8'(out_valid), 8'h01);
    chk("glitch_q", 8'(out_q), 8'h00);
    chk("glitch_err", 8'(out_err), 8'h00);
    consume();

    // Stuck stage: Q never leaves NULL, DATA phase times out after 20
    qt_m = 1'b0; qf_m = 1'b0;
    accept(4'b1111);
    ticks(19);
    chk("stuck_rails_e19", rails, 8'b1010_1010);
    tick();
    chk("stuck_null_e20", rails, 8'h00);
    chk("stuck_valid_e20", 8'(out_valid), 8'h00);
    tick();
    chk("stuck_valid_e21", 8'(out_valid), 8'h00);
    tick();
    chk("stuck_valid_e22", 8'(out_valid), 8'h01);
    chk("stuck_err", 8'(out_err), 8'h01);
    chk("stuck_q", 8'(out_q), 8'h00);
    consume();

    // Illegal: both rails high during DATA and held through NULL phase
    qt_m = 1'b0; qf_m = 1'b0;
    accept(4'b0000);
    tick();
    qt_m = 1'b1; qf_m = 1'b1;
    ticks(2);
    chk("illegal_rails_e3", rails, 8'b0101_0101);
    tick();
    chk("illegal_null_e4", rails, 8'h00);
    ticks(19);
    chk("illegal_valid_e23", 8'(out_valid), 8'h00);
    tick();
    chk("illegal_valid_e24", 8'(out_valid), 8'h01);
    chk("illegal_err", 8'(out_err), 8'h02);
    chk("illegal_q", 8'(out_q), 8'h00);
    qt_m = 1'b0; qf_m = 1'b0;
    consume();

    // Backpressure: result held while out_ready stays low
    man = 1'b0;
    accept(4'b1100);
    ticks(8);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 8'(out_valid), 8'h01);
      chk("bp_q", 8'(out_q), 8'h01);
      chk("bp_err", 8'(out_err), 8'h00);
      chk("bp_ready", 8'(in_ready), 8'h00);
      tick();
    end
    consume();

    // Reset mid-DATA: rails drop at once, no result follows
    accept(4'b1100);
    ticks(2);
    chk("mid_rails_pre", rails, 8'b1010_0101);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rails", rails, 8'h00);
    chk("mid_rst_valid", 8'(out_valid), 8'h00);
    chk("mid_rst_ready", 8'(in_ready), 8'h01);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("post_rst_valid", 8'(out_valid), 8'h00);
      chk("post_rst_rails", rails, 8'h00);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
